// File: rtl/async_fifo_pkg.sv
// Shared constants and helper functions for the async FIFO pointer-crossing logic.
package async_fifo_pkg;

    // Which side of the FIFO a receiver instance sits on.
    localparam int SIDE_RD = 0;
    localparam int SIDE_WR = 1;

    // FIFO depth addressed by a pointer of the given width (the MSB is the wrap bit).
    function automatic int ptr_depth(input int bits);
        return 1 << (bits - 1);
    endfunction

    // Number of set bits in a vector.
    // Narrower vectors are zero-extended by the caller.
    function automatic int popcount(input logic [31:0] value);
        int count;
        count = 0;
        for (int i = 0; i < 32; i++) begin
            count += int'(value[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/async_fifo_gcodetobin.sv
// Combinational gray-to-binary decoder.
// This is the inverse of the binary-to-gray converter used by the pointer counters.
module async_fifo_gcodetobin #(
    parameter int SIGNAL_WIDTH = 4
) (
    input  logic [SIGNAL_WIDTH-1:0] greycode,
    output logic [SIGNAL_WIDTH-1:0] binary
);

    // Each binary bit is the XOR of all gray bits at or above its position.
    for (genvar gi = 0; gi < SIGNAL_WIDTH; gi++) begin : gen_bit
        assign binary[gi] = ^greycode[SIGNAL_WIDTH-1:gi];
    end

endmodule

// File: rtl/async_fifo_gcode_receiver.sv
// Receiving end of the gray-code pointer crossing for one clock domain of the async FIFO.
// It synchronises the remote gray pointer and compares it with the next local pointer.
// From that comparison it produces a registered empty/full flag, a registered occupancy
// level and a sticky flag that is set when the remote pointer makes an illegal multi-bit step.
module async_fifo_gcode_receiver
    import async_fifo_pkg::*;
#(
    parameter int COUNTER_BITS = 4,
    parameter int SYNC_STAGES  = 2,   // legal range 2..4
    parameter int SIDE         = SIDE_RD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [COUNTER_BITS-1:0] remote_gcode_ptr,
    input  logic [COUNTER_BITS-1:0] local_gcode_ptr_next,
    output logic                    status_flag,
    output logic [COUNTER_BITS-1:0] level,
    output logic [COUNTER_BITS-1:0] remote_bin_sync,
    output logic                    gray_err
);

    localparam int DEPTH       = ptr_depth(COUNTER_BITS);
    // rsync and prev_rsync both carry live data only after this many edges out of reset.
    localparam int WARM_CYCLES = SYNC_STAGES + 1;
    localparam int WARM_BITS   = $clog2(WARM_CYCLES + 1);
    // Full means the local pointer is one lap ahead.
    // In gray code that inverts the top two bits of the remote pointer.
    localparam logic [COUNTER_BITS-1:0] FULL_MASK = COUNTER_BITS'(3) << (COUNTER_BITS - 2);
    // Empty on the read side and not-full on the write side.
    localparam logic FLAG_RESET = (SIDE == SIDE_RD);

    logic [COUNTER_BITS-1:0] sync_reg [SYNC_STAGES];
    logic [COUNTER_BITS-1:0] rsync;
    logic [COUNTER_BITS-1:0] prev_rsync_reg;
    logic [COUNTER_BITS-1:0] remote_bin;
    logic [COUNTER_BITS-1:0] local_bin_next;
    logic [COUNTER_BITS-1:0] level_reg;
    logic [COUNTER_BITS-1:0] level_next;
    logic [COUNTER_BITS-1:0] remote_bin_sync_reg;
    logic                    status_flag_reg;
    logic                    status_flag_next;
    logic                    gray_err_reg;
    logic                    gray_err_next;
    logic [WARM_BITS-1:0]    warm_reg;
    logic                    warm_done;
    logic                    multi_bit_step;

    // Synchroniser chain.
    // Stage 0 samples the asynchronous pointer directly, with no logic in front of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= remote_gcode_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign rsync = sync_reg[SYNC_STAGES-1];

    async_fifo_gcodetobin #(
        .SIGNAL_WIDTH(COUNTER_BITS)
    ) u_remote_dec (
        .greycode(rsync),
        .binary  (remote_bin)
    );

    async_fifo_gcodetobin #(
        .SIGNAL_WIDTH(COUNTER_BITS)
    ) u_local_dec (
        .greycode(local_gcode_ptr_next),
        .binary  (local_bin_next)
    );

    // Next flag and level, compared against the next local pointer.
    // This means the local side adds no extra cycle of lag.
    always_comb begin
        status_flag_next = 1'b0;
        level_next       = '0;
        if (SIDE == SIDE_WR) begin
            status_flag_next = (local_gcode_ptr_next == (rsync ^ FULL_MASK));
            level_next       = local_bin_next - remote_bin;
        end else begin
            status_flag_next = (local_gcode_ptr_next == rsync);
            level_next       = remote_bin - local_bin_next;
        end
    end

    // The multi-bit step check is masked until the synchroniser and prev_rsync hold live data.
    assign warm_done      = (warm_reg == WARM_BITS'(WARM_CYCLES));
    assign multi_bit_step = (popcount(32'(rsync ^ prev_rsync_reg)) > 1);
    assign gray_err_next  = gray_err_reg | (warm_done & multi_bit_step);

    // Output registers, the warm-up counter and the previous-rsync copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_rsync_reg      <= '0;
            status_flag_reg     <= FLAG_RESET;
            level_reg           <= '0;
            remote_bin_sync_reg <= '0;
            gray_err_reg        <= 1'b0;
            warm_reg            <= '0;
        end else begin
            prev_rsync_reg      <= rsync;
            status_flag_reg     <= status_flag_next;
            level_reg           <= level_next;
            remote_bin_sync_reg <= remote_bin;
            gray_err_reg        <= gray_err_next;
            if (!warm_done) begin
                warm_reg <= warm_reg + 1'b1;
            end
        end
    end

    assign status_flag     = status_flag_reg;
    assign level           = level_reg;
    assign remote_bin_sync = remote_bin_sync_reg;
    assign gray_err        = gray_err_reg;

`ifdef ASSERT_ON
    // Occupancy can never exceed the FIFO depth.
    a_level_range : assert property (@(posedge clk) disable iff (reset)
        int'(level_reg) <= DEPTH);

    if (SIDE == SIDE_RD) begin : gen_rd_chk
        // Empty flag and zero occupancy are derived from the same pointer pair.
        a_empty_level : assert property (@(posedge clk) disable iff (reset)
            status_flag_reg == (level_reg == '0));
    end else begin : gen_wr_chk
        // Full flag and full occupancy are derived from the same pointer pair.
        a_full_level : assert property (@(posedge clk) disable iff (reset)
            status_flag_reg == (level_reg == COUNTER_BITS'(DEPTH)));
    end
`endif

endmodule

// File: tb/tb_async_fifo_gcode_receiver.sv
// Directed testbench for async_fifo_gcode_receiver.
// It drives one read-side and one write-side instance with hand-computed expectations.
module tb_async_fifo_gcode_receiver;

    logic       clk;
    logic       reset;
    logic [3:0] rd_remote, rd_local, wr_remote, wr_local;
    logic       rd_flag, wr_flag, rd_err, wr_err;
    logic [3:0] rd_level, wr_level, rd_rbin, wr_rbin;

    int vecs = 0;
    int errs = 0;

    async_fifo_gcode_receiver #(.COUNTER_BITS(4), .SYNC_STAGES(2), .SIDE(0)) u_rd (
        .clk(clk), .reset(reset),
        .remote_gcode_ptr(rd_remote), .local_gcode_ptr_next(rd_local),
        .status_flag(rd_flag), .level(rd_level),
        .remote_bin_sync(rd_rbin), .gray_err(rd_err)
    );

    async_fifo_gcode_receiver #(.COUNTER_BITS(4), .SYNC_STAGES(2), .SIDE(1)) u_wr (
        .clk(clk), .reset(reset),
        .remote_gcode_ptr(wr_remote), .local_gcode_ptr_next(wr_local),
        .status_flag(wr_flag), .level(wr_level),
        .remote_bin_sync(wr_rbin), .gray_err(wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Binary to gray conversion, used to build pointer stimulus.
    function automatic logic [3:0] g(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rd_remote = 4'h0; rd_local = 4'h0; wr_remote = 4'h0; wr_local = 4'h0;
        tick(2);
        vecs++; if (rd_flag !== 1'b1) begin errs++; $display("FAIL reset_rd_flag: got %b want 1", rd_flag); end
        vecs++; if (rd_level !== 4'd0) begin errs++; $display("FAIL reset_rd_level: got %0d want 0", rd_level); end
        vecs++; if (rd_err !== 1'b0) begin errs++; $display("FAIL reset_rd_err: got %b want 0", rd_err); end
        vecs++; if (rd_rbin !== 4'd0) begin errs++; $display("FAIL reset_rd_rbin: got %0d want 0", rd_rbin); end
        vecs++; if (wr_flag !== 1'b0) begin errs++; $display("FAIL reset_wr_flag: got %b want 0", wr_flag); end
        vecs++; if (wr_level !== 4'd0) begin errs++; $display("FAIL reset_wr_level: got %0d want 0", wr_level); end
        reset = 1'b0;
        tick(5);
        vecs++; if (rd_flag !== 1'b1 || rd_err !== 1'b0) begin errs++; $display("FAIL idle_rd: got flag=%b err=%b want flag=1 err=0", rd_flag, rd_err); end
        $display("test_reset done: vectors=%0d miscompares=%0d", vecs, errs);
    endtask

    // Read side: a remote step takes three edges to appear; a local step takes one.
    task automatic test_remote_latency;
        rd_remote = g(1);
        for (int e = 1; e <= 3; e++) begin
            tick(1);
            vecs++;
            if (rd_flag !== (e < 3) || rd_level !== ((e < 3) ? 4'd0 : 4'd1)) begin
                errs++;
                $display("FAIL remote_latency edge %0d: got flag=%b level=%0d want flag=%b level=%0d",
                         e, rd_flag, rd_level, (e < 3), (e < 3) ? 0 : 1);
            end
        end
        vecs++; if (rd_rbin !== 4'd1) begin errs++; $display("FAIL remote_bin_sync: got %0d want 1", rd_rbin); end
        rd_local = g(1);
        tick(1);
        vecs++; if (rd_flag !== 1'b1 || rd_level !== 4'd0) begin errs++; $display("FAIL local_latency: got flag=%b level=%0d want flag=1 level=0", rd_flag, rd_level); end
        $display("test_remote_latency done: vectors=%0d miscompares=%0d", vecs, errs);
    endtask

    // Write side: fill from 0 to 8; full asserts on the same edge as the local update.
    task automatic test_wr_fill;
        for (int b = 1; b <= 8; b++) begin
            wr_local = g(b);
            tick(1);
            vecs++;
            if (wr_level !== 4'(b) || wr_flag !== (b == 8)) begin
                errs++;
                $display("FAIL wr_fill b=%0d: got level=%0d flag=%b want level=%0d flag=%b",
                         b, wr_level, wr_flag, b, (b == 8));
            end
        end
        $display("test_wr_fill done: vectors=%0d miscompares=%0d", vecs, errs);
    endtask

    // Read side wrap-around: remote moves 15->0 while local moves 12->15->0.
    task automatic test_wrap;
        rd_remote = g(15); rd_local = g(12);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        vecs++; if (rd_level !== 4'd3 || rd_flag !== 1'b0) begin errs++; $display("FAIL wrap_start: got level=%0d flag=%b want level=3 flag=0", rd_level, rd_flag); end
        rd_remote = g(0);
        tick(3);
        vecs++; if (rd_level !== 4'd4) begin errs++; $display("FAIL wrap_remote: got level=%0d want 4", rd_level); end
        for (int b = 13; b <= 15; b++) begin
            rd_local = g(b);
            tick(1);
            vecs++;
            if (rd_level !== 4'(16 - b) || rd_flag !== 1'b0) begin
                errs++;
                $display("FAIL wrap_local b=%0d: got level=%0d flag=%b want level=%0d flag=0", b, rd_level, rd_flag, 16 - b);
            end
        end
        rd_local = g(0);
        tick(1);
        vecs++; if (rd_level !== 4'd0 || rd_flag !== 1'b1) begin errs++; $display("FAIL wrap_empty: got level=%0d flag=%b want level=0 flag=1", rd_level, rd_flag); end
        vecs++; if (rd_err !== 1'b0) begin errs++; $display("FAIL wrap_err: got %b want 0", rd_err); end
        $display("test_wrap done: vectors=%0d miscompares=%0d", vecs, errs);
    endtask

    // An illegal 2-bit remote jump sets the sticky error one edge after it reaches rsync.
    task automatic test_gray_err;
        rd_remote = 4'b0011;
        tick(2);
        vecs++; if (rd_err !== 1'b0) begin errs++; $display("FAIL gray_err_early: got %b want 0", rd_err); end
        tick(1);
        vecs++; if (rd_err !== 1'b1) begin errs++; $display("FAIL gray_err_set: got %b want 1", rd_err); end
        vecs++; if (rd_level !== 4'd2) begin errs++; $display("FAIL gray_err_level: got %0d want 2", rd_level); end
        rd_remote = g(3);
        tick(3);
        rd_remote = g(4);
        tick(3);
        vecs++; if (rd_err !== 1'b1) begin errs++; $display("FAIL gray_err_sticky: got %b want 1", rd_err); end
        $display("test_gray_err done: vectors=%0d miscompares=%0d", vecs, errs);
    endtask

    // Reset mid-stream; the 3-bit refill step (0000 -> 0111) must not raise gray_err.
    task automatic test_reset_mid;
        rd_remote = g(5);
        tick(4);
        vecs++; if (rd_level !== 4'd5) begin errs++; $display("FAIL mid_level_pre: got %0d want 5", rd_level); end
        reset = 1'b1;
        tick(1);
        vecs++; if (rd_level !== 4'd0 || rd_flag !== 1'b1 || rd_err !== 1'b0 || rd_rbin !== 4'd0) begin
            errs++;
            $display("FAIL mid_reset_rd: got level=%0d flag=%b err=%b rbin=%0d want 0 1 0 0", rd_level, rd_flag, rd_err, rd_rbin);
        end
        vecs++; if (wr_flag !== 1'b0 || wr_level !== 4'd0) begin errs++; $display("FAIL mid_reset_wr: got flag=%b level=%0d want 0 0", wr_flag, wr_level); end
        reset = 1'b0;
        tick(6);
        vecs++; if (rd_err !== 1'b0) begin errs++; $display("FAIL refill_err: got %b want 0", rd_err); end
        vecs++; if (rd_level !== 4'd5 || rd_flag !== 1'b0) begin errs++; $display("FAIL refill_level: got level=%0d flag=%b want 5 0", rd_level, rd_flag); end
        vecs++; if (wr_flag !== 1'b1 || wr_level !== 4'd8) begin errs++; $display("FAIL refill_wr_full: got flag=%b level=%0d want 1 8", wr_flag, wr_level); end
        $display("test_reset_mid done: vectors=%0d miscompares=%0d", vecs, errs);
    endtask

    initial begin
        test_reset();
        test_remote_latency();
        test_wr_fill();
        test_wrap();
        test_gray_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/async_fifo_gcode_receiver.md
Name: async_fifo_gcode_receiver

Overview:
Receiving end of the gray-code pointer crossing. It takes the gray pointer driven by the opposite clock domain's counter and passes it through a multi-flop synchronizer. It then decodes the synchronized pointer to binary and compares it with the local pointer. From that comparison it produces a registered status flag (empty on the read side, full on the write side), a registered occupancy level, and a sticky protocol-error flag. One instance sits in each clock domain of the async FIFO, beside that domain's gray counter.

Parameters:
COUNTER_BITS, 4, pointer width; FIFO depth is 2**(COUNTER_BITS-1); MSB is the wrap bit.
SYNC_STAGES, 2, number of synchronizer flops on the remote pointer; legal range is 2 to 4.
SIDE, 0, 0 = read side (flag means empty), 1 = write side (flag means full).

Ports:
clk  input  1  local-domain clock.
reset  input  1  synchronous, active-high reset.
remote_gcode_ptr  input  COUNTER_BITS  gray pointer from the other domain; asynchronous to clk.
local_gcode_ptr_next  input  COUNTER_BITS  gray value the local counter registers at this clk edge.
status_flag  output  1  registered empty flag (SIDE=0) or full flag (SIDE=1).
level  output  COUNTER_BITS  registered occupancy, range 0 to 2**(COUNTER_BITS-1).
remote_bin_sync  output  COUNTER_BITS  synchronized remote pointer, decoded to binary.
gray_err  output  1  sticky flag: synchronized remote pointer moved by more than 1 bit in one cycle.

Behaviour:
- Single clock domain (clk); synchronous active-high reset; no logic outside clk.
- Synchronizer:
  - sync[0] <= remote_gcode_ptr; sync[i] <= sync[i-1].
  - rsync = sync[SYNC_STAGES-1].
  - The first stage is the only path fed by an asynchronous signal; no logic in front of it.
- Decode: remote_bin = gray-to-binary(rsync), and local_bin_next = gray-to-binary(local_gcode_ptr_next). Both decodes are combinational.
- status_flag is registered each cycle:
  - SIDE=0: status_flag <= (local_gcode_ptr_next == rsync).
  - SIDE=1: status_flag <= (local_gcode_ptr_next == {~rsync[MSB:MSB-1], rsync[MSB-2:0]}).
  - Because the flag uses the next local pointer, it is valid in the same cycle the local pointer updates; there is no extra lag on the local side.
- level is registered, with modulo 2**COUNTER_BITS subtraction so wrap-around is correct:
  - SIDE=0: level <= remote_bin - local_bin_next.
  - SIDE=1: level <= local_bin_next - remote_bin.
- remote_bin_sync <= remote_bin, registered.
- Latency:
  - A remote pointer change reaches status_flag, level and remote_bin_sync SYNC_STAGES+1 clk edges after it is captured.
  - A local pointer change reaches them 1 edge after it is captured.
- Flags are conservative by design:
  - Stale remote data can hold empty or full asserted longer than the true condition.
  - Stale remote data never de-asserts them early.
- gray_err:
  - Keep prev_rsync, a registered copy of rsync.
  - If popcount(rsync ^ prev_rsync) > 1 and the block is out of reset for at least SYNC_STAGES+1 cycles, set gray_err = 1.
  - gray_err stays set until reset.
  - A warm-up counter masks the check during synchronizer fill.
- Reset values:
  - All sync stages, prev_rsync, remote_bin_sync and level = 0.
  - status_flag = 1 when SIDE=0 (empty); status_flag = 0 when SIDE=1 (not full).
  - gray_err = 0; warm-up counter = 0.
- Reset mid-operation: all state returns to its reset value on the next edge. The pipeline refills from the live remote pointer, and gray_err stays masked during refill.
- Simultaneous local and remote changes: both are sampled at the same edge, and the result reflects both values with no priority between them.
- Under ASSERT_ON:
  - Assert level <= 2**(COUNTER_BITS-1).
  - Assert status_flag == (level == 0) when SIDE=0.
  - Assert status_flag == (level == 2**(COUNTER_BITS-1)) when SIDE=1.
  - Each assertion is disabled during reset.

Decomposition:
- async_fifo_pkg holds:
  - the side encoding as constants SIDE_RD = 0 and SIDE_WR = 1;
  - the function ptr_depth(bits) = 2**(bits-1);
  - the popcount function used by the gray_err check.
- One sub-module, async_fifo_gcodetobin:
  - combinational; parameter SIGNAL_WIDTH; ports greycode in, binary out;
  - it is the inverse of the existing binary-to-gray converter;
  - instantiated twice, once for the remote pointer and once for the local pointer.

Test Plan:
1. Reset, SIDE=0, both pointers 0 -> status_flag=1, level=0, gray_err=0; SIDE=1 instance -> status_flag=0.
2. SIDE=0, local next=0, remote gray steps 0->1 (binary 1) -> exactly SYNC_STAGES+1 edges later status_flag=0 and level=1; flag never drops before that edge.
3. SIDE=1, local binary sequence 0..8 with remote fixed at 0 -> level counts 1..8; status_flag=1 at binary 8 (gray 4'b1100 vs remote 4'b0000), same edge as the local update.
4. Wrap-around, SIDE=0, remote binary 15->0 and local binary 12->15 -> level 3 (15-12), then 1 (0-15 mod 16); status_flag=1 only when both pointers equal binary 0.
5. Remote jumps gray 4'b0000->4'b0011 after warm-up -> gray_err=1 the edge after that change reaches rsync; it stays 1 through later legal 1-bit steps until reset.
6. Assert reset mid-stream with level=5 -> next edge level=0 and status_flag at its reset value; a 3-bit remote jump during refill leaves gray_err=0.
